adc_fifo_reader: RTL

ADC_FIFO_READER -- requirements
Module: adc_fifo_reader

---
 rtl/adc_fifo_reader_if.sv | 26 ++
 rtl/adc_fifo_reader.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/adc_fifo_reader_if.sv
// Four-channel FIFO read port plus the outgoing frame stream of adc_fifo_reader.
// The reader uses the master modport and its environment uses slave.
interface adc_fifo_reader_if;
  logic [3:0]  rdempty;
  logic [31:0] ch0_q;
  logic [31:0] ch1_q;
  logic [31:0] ch2_q;
  logic [31:0] ch3_q;
  logic        rdreq;
  logic [31:0] frame_data;
  logic [1:0]  frame_channel;
  logic        frame_valid;
  logic        frame_ready;
  logic        frame_sof;
  logic        frame_eof;

  modport master (
    input  rdempty, ch0_q, ch1_q, ch2_q, ch3_q, frame_ready,
    output rdreq, frame_data, frame_channel, frame_valid, frame_sof, frame_eof
  );

  modport slave (
    output rdempty, ch0_q, ch1_q, ch2_q, ch3_q, frame_ready,
    input  rdreq, frame_data, frame_channel, frame_valid, frame_sof, frame_eof
  );
endinterface

// File: rtl/adc_fifo_reader.sv
// Reads one sample from each of four channel FIFOs with a single shared rdreq and
// streams them out as a four-beat frame, watching the empty flags for desync.
module adc_fifo_reader #(
  parameter int READ_LATENCY = 1,
  parameter int DESYNC_LIMIT = 16
) (
  input  logic              system_clock_i,
  input  logic              reset_i,
  input  logic              enable_i,
  input  logic              clear_status_i,
  output logic              desync_o,
  output logic [15:0]       frame_count_o,
  adc_fifo_reader_if.master bus
);

  localparam int             CNT_W    = $clog2(DESYNC_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(DESYNC_LIMIT);
  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(DESYNC_LIMIT - 1);
  localparam logic [1:0]     LATENCY  = 2'(READ_LATENCY);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    SEND
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            waitCnt_q, waitCnt_d;
  logic [1:0]            channel_q, channel_d;
  logic [3:0][31:0]      holdBuf_q, holdBuf_d;
  logic [CNT_W-1:0]      mismatchCnt_q, mismatchCnt_d;
  logic                  desync_q, desync_d;
  logic [15:0]           frameCount_q, frameCount_d;
  logic                  armed_q;

  logic                  emptyAll;
  logic                  emptyNone;
  logic                  emptyMismatch;
  logic                  setDesync;
  logic                  rdreq;
  logic                  frameValid;

  assign emptyAll      = &bus.rdempty;
  assign emptyNone     = ~|bus.rdempty;
  assign emptyMismatch = ~(emptyAll | emptyNone);

  // armed_q keeps rdreq low until one edge has passed since reset release.
  always_ff @(posedge system_clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= IDLE;
      waitCnt_q     <= 2'd0;
      channel_q     <= 2'd0;
      holdBuf_q     <= '0;
      mismatchCnt_q <= '0;
      desync_q      <= 1'b0;
      frameCount_q  <= 16'd0;
      armed_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      waitCnt_q     <= waitCnt_d;
      channel_q     <= channel_d;
      holdBuf_q     <= holdBuf_d;
      mismatchCnt_q <= mismatchCnt_d;
      desync_q      <= desync_d;
      frameCount_q  <= frameCount_d;
      armed_q       <= 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    waitCnt_d     = waitCnt_q;
    channel_d     = channel_q;
    holdBuf_d     = holdBuf_q;
    mismatchCnt_d = mismatchCnt_q;
    frameCount_d  = frameCount_q;
    setDesync     = 1'b0;
    rdreq         = 1'b0;
    frameValid    = 1'b0;

    case (state_q)
      IDLE: begin
        // Empty flags only matter between frames; the counter saturates so a
        // persistent disagreement keeps re-asserting the sticky flag.
        if (emptyMismatch) begin
          if (mismatchCnt_q != LIMIT) begin
            mismatchCnt_d = mismatchCnt_q + CNT_W'(1);
          end
          if (mismatchCnt_q >= LIMIT_M1) begin
            setDesync = 1'b1;
          end
        end else begin
          mismatchCnt_d = '0;
        end

        if (armed_q && enable_i && emptyNone) begin
          rdreq     = 1'b1;
          waitCnt_d = 2'd1;
          state_d   = WAIT;
        end
      end

      WAIT: begin
        if (waitCnt_q == LATENCY) begin
          holdBuf_d = {bus.ch3_q, bus.ch2_q, bus.ch1_q, bus.ch0_q};
          channel_d = 2'd0;
          state_d   = SEND;
        end else begin
          waitCnt_d = waitCnt_q + 2'd1;
        end
      end

      SEND: begin
        frameValid = 1'b1;
        if (bus.frame_ready) begin
          if (channel_q == 2'd3) begin
            frameCount_d = frameCount_q + 16'd1;
            channel_d    = 2'd0;
            state_d      = IDLE;
          end else begin
            channel_d = channel_q + 2'd1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // A same-cycle set beats clear_status.
  assign desync_d = setDesync | (desync_q & ~clear_status_i);

  assign bus.rdreq         = rdreq;
  assign bus.frame_valid   = frameValid;
  assign bus.frame_channel = channel_q;
  assign bus.frame_data    = frameValid ? holdBuf_q[channel_q] : 32'd0;
  assign bus.frame_sof     = frameValid & (channel_q == 2'd0);
  assign bus.frame_eof     = frameValid & (channel_q == 2'd3);

  assign desync_o      = desync_q;
  assign frame_count_o = frameCount_q;

endmodule
